mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that sits on the core's data-memory bus as a responder.
- The core's stores (Mem_Write, Address, Write_Data) push bytes into a TX FIFO and program the baud divisor.
- The core's loads (Mem_Read, Address) return status with zero-latency combinational read data, as the single-cycle datapath requires.
- The top level muxes Read_Data_o against Data_Memory using sel_o.

---
 rtl/mmio_uart_tx.sv | 245 ++++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Stores fill a TX FIFO and set the baud divisor; loads return status.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Mem_Write_i,
   input  logic        Mem_Read_i,
   input  logic [31:0] Address_i,
   input  logic [31:0] Write_Data_i,
   output logic [31:0] Read_Data_o,
   output logic        sel_o,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // bus decode
   logic       sel;
   logic [1:0] off;
   logic       wr_en;
   logic       wr_tx;
   logic       wr_status;
   logic       wr_baud;
   logic       wr_ctrl;

   // fifo
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // control registers
   logic        ovf;
   logic [15:0] baud_div;
   logic [1:0]  ctrl;
   logic        irq;

   // transmitter
   state_t      state;
   state_t      state_nx;
   logic [15:0] baud_cnt;
   logic [15:0] baud_cnt_nx;
   logic [15:0] div_q;
   logic [15:0] div_nx;
   logic [2:0]  bit_idx;
   logic [2:0]  bit_idx_nx;
   logic [7:0]  shift;
   logic [7:0]  shift_nx;
   logic        tick;
   logic        can_start;
   logic        tx;
   logic        tx_nx;

   logic [31:0] status;
   logic [31:0] rd_mux;
   logic        unused;

   assign sel       = (Address_i[31:4] == BASE_ADDR[31:4]);
   assign off       = Address_i[3:2];
   assign wr_en     = Mem_Write_i & sel;
   assign wr_tx     = wr_en & (off == 2'd0);
   assign wr_status = wr_en & (off == 2'd1);
   assign wr_baud   = wr_en & (off == 2'd2);
   assign wr_ctrl   = wr_en & (off == 2'd3);

   assign full  = (count == CW'(FIFO_DEPTH));
   assign empty = (count == '0);

   // a pop in the same edge frees the slot, so a full push still lands
   assign push = wr_tx & (~full | pop);

   assign unused = ^{Address_i[1:0], Write_Data_i[31:16]};

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= Write_Data_i[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (wr_tx && full && !pop) begin
            ovf <= 1'b1;
         end else if (wr_status && Write_Data_i[3]) begin
            ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baud_div <= DEFAULT_DIV;
         ctrl     <= 2'b00;
         irq      <= 1'b0;
      end else begin
         if (wr_baud) begin
            baud_div <= Write_Data_i[15:0];
         end
         if (wr_ctrl) begin
            ctrl <= Write_Data_i[1:0];
         end
         irq <= empty & ctrl[1];
      end
   end

   assign tick      = (baud_cnt == div_q);
   assign can_start = ctrl[0] & ~empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         div_q    <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_cnt_nx;
         div_q    <= div_nx;
         bit_idx  <= bit_idx_nx;
         shift    <= shift_nx;
         tx       <= tx_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      baud_cnt_nx = baud_cnt + 16'd1;
      div_nx      = div_q;
      bit_idx_nx  = bit_idx;
      shift_nx    = shift;
      pop         = 1'b0;
      unique case (state)
         IDLE: begin
            baud_cnt_nx = '0;
            if (can_start) begin
               pop      = 1'b1;
               shift_nx = fifo_mem[rd_ptr];
               div_nx   = baud_div;
               state_nx = START;
            end
         end
         START: begin
            if (tick) begin
               baud_cnt_nx = '0;
               bit_idx_nx  = '0;
               state_nx    = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               baud_cnt_nx = '0;
               shift_nx    = {1'b0, shift[7:1]};
               bit_idx_nx  = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nx = STOP;
               end
            end
         end
         STOP: begin
            if (tick) begin
               baud_cnt_nx = '0;
               if (can_start) begin
                  // back-to-back frame with no idle gap
                  pop      = 1'b1;
                  shift_nx = fifo_mem[rd_ptr];
                  div_nx   = baud_div;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // line level is registered from the next state so it never glitches
   always_comb begin
      tx_nx = 1'b1;
      unique case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase
   end

   assign status = {16'h0000,
                    {(8 - CW){1'b0}}, count,
                    4'h0, ovf, empty, full,
                    (state != IDLE)};

   always_comb begin
      rd_mux = '0;
      unique case (off)
         2'd0: rd_mux = '0;
         2'd1: rd_mux = status;
         2'd2: rd_mux = {16'h0000, baud_div};
         2'd3: rd_mux = {30'h0, ctrl};
         default: rd_mux = '0;
      endcase
   end

   assign Read_Data_o = (Mem_Read_i && sel) ? rd_mux : 32'h0;
   assign sel_o       = sel;
   assign tx_o        = tx;
   assign irq_o       = irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model plus
// directed literal checks and a randomized bus phase.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'h1001_0100;
   localparam int          DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mw = 1'b0;
   logic        mr = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        sel;
   logic        tx;
   logic        irq;

   int nchk = 0;
   int nerr = 0;
   bit chk_on = 1'b0;

   mmio_uart_tx dut (
      .clk          (clk),
      .reset        (reset),
      .Mem_Write_i  (mw),
      .Mem_Read_i   (mr),
      .Address_i    (addr),
      .Write_Data_i (wdata),
      .Read_Data_o  (rdata),
      .sel_o        (sel),
      .tx_o         (tx),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   // reference model: byte queue plus the remaining line levels of the
   // current frame, one entry per clock cycle
   logic [7:0] mq[$];
   bit         mframe[$];
   int         m_baud = 433;
   logic [1:0] m_ctrl = 2'b00;
   bit         m_ovf = 1'b0;
   bit         m_irq = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic build_frame(input logic [7:0] b);
      bit lvl;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) lvl = 1'b0;
         else if (k == 9) lvl = 1'b1;
         else lvl = b[k-1];
         for (int c = 0; c <= m_baud; c++) mframe.push_back(lvl);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         mframe.delete();
         m_baud = 433;
         m_ctrl = 2'b00;
         m_ovf  = 1'b0;
         m_irq  = 1'b0;
      end else begin : step
         bit emp0;
         bit irq_nx;
         bit msel;
         emp0   = (mq.size() == 0);
         irq_nx = emp0 && m_ctrl[1];
         msel   = (addr[31:4] == BASE[31:4]);
         if (mframe.size() > 0) void'(mframe.pop_front());
         if (mframe.size() == 0 && m_ctrl[0] && !emp0)
            build_frame(mq.pop_front());
         if (mw && msel) begin
            case (addr[3:2])
               2'd0: begin
                  if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
                  else m_ovf = 1'b1;
               end
               2'd1: if (wdata[3]) m_ovf = 1'b0;
               2'd2: m_baud = int'(wdata[15:0]);
               default: m_ctrl = wdata[1:0];
            endcase
         end
         m_irq = irq_nx;
      end
   end

   function automatic logic [31:0] exp_rd();
      logic [31:0] v;
      v = 32'h0;
      if (mr && addr[31:4] == BASE[31:4]) begin
         case (addr[3:2])
            2'd1: begin
               v[0]    = (mframe.size() > 0);
               v[1]    = (mq.size() == DEPTH);
               v[2]    = (mq.size() == 0);
               v[3]    = m_ovf;
               v[15:8] = 8'(mq.size());
            end
            2'd2: v = 32'(m_baud);
            2'd3: v = {30'h0, m_ctrl};
            default: v = 32'h0;
         endcase
      end
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("sel", sel, {31'h0, addr[31:4] == BASE[31:4]});
         chk("rdata", rdata, exp_rd());
         chk("tx", tx, (mframe.size() > 0) ? mframe[0] : 1'b1);
         chk("irq", irq, m_irq);
      end
   end

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      mw = 1'b1; mr = 1'b0; addr = a; wdata = d;
      @(posedge clk); #1;
      mw = 1'b0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic rd_lit(input logic [31:0] a, input logic [31:0] exp,
                         input string n);
      mr = 1'b1; addr = a;
      @(negedge clk);
      chk(n, rdata, exp);
      @(posedge clk); #1;
      mr = 1'b0; addr = 32'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] fr;
      logic [9:0] fr2;
      int r;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      chk_on = 1'b1;

      // reset state
      mr = 1'b1; addr = BASE + 32'h4;
      @(negedge clk);
      chk("rst_sel", sel, 1);
      chk("rst_tx", tx, 1);
      chk("rst_irq", irq, 0);
      @(posedge clk); #1;
      rd_lit(BASE + 32'h4, 32'h0000_0004, "rst_status");
      rd_lit(BASE + 32'h8, 32'h0000_01B1, "rst_baud");

      // single 0xA5 frame, four cycles per bit
      bus_wr(BASE + 32'h8, 32'd3);
      bus_wr(BASE + 32'hC, 32'h1);
      bus_wr(BASE + 32'h0, 32'hA5);
      fr = {1'b1, 8'hA5, 1'b0};
      mr = 1'b1; addr = BASE + 32'h4;
      for (int i = 0; i < 42; i++) begin
         @(negedge clk);
         chk("a5_tx", tx,
             (i >= 1 && i <= 40) ? {31'h0, fr[(i-1)/4]} : 32'h1);
         chk("a5_busy", rdata[0], (i >= 1 && i <= 40) ? 1 : 0);
      end
      @(posedge clk); #1;
      mr = 1'b0; addr = 32'h0;

      // overflow with transmitter disabled
      bus_wr(BASE + 32'hC, 32'h0);
      for (int i = 0; i < 9; i++) bus_wr(BASE, 32'h30 + i);
      rd_lit(BASE + 32'h4, 32'h0000_080A, "ovf_status");
      bus_wr(BASE + 32'h4, 32'h8);
      rd_lit(BASE + 32'h4, 32'h0000_0802, "ovf_clear");
      bus_wr(BASE + 32'h8, 32'd0);
      bus_wr(BASE + 32'hC, 32'h1);
      idle(100);
      rd_lit(BASE + 32'h4, 32'h0000_0004, "drain_status");

      // back-to-back frames at one cycle per bit
      bus_wr(BASE + 32'hC, 32'h3);
      bus_wr(BASE, 32'h01);
      bus_wr(BASE, 32'h02);
      fr  = {1'b1, 8'h01, 1'b0};
      fr2 = {1'b1, 8'h02, 1'b0};
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         chk("b2b_tx", tx,
             i < 10 ? {31'h0, fr[i]} :
             i < 20 ? {31'h0, fr2[i-10]} : 32'h1);
      end
      idle(2);
      @(negedge clk);
      chk("b2b_irq", irq, 1);
      idle(1);
      rd_lit(BASE + 32'h4, 32'h0000_0004, "b2b_status");

      // accesses outside the window
      bus_wr(BASE + 32'h10, 32'h55);
      rd_lit(BASE + 32'h4, 32'h0000_0004, "oob_status");
      mr = 1'b1; addr = BASE - 32'h4;
      @(negedge clk);
      chk("oob_sel", sel, 0);
      chk("oob_rdata", rdata, 0);
      @(posedge clk); #1;
      mr = 1'b0; addr = 32'h0;

      // reset during data bit 3
      bus_wr(BASE + 32'h8, 32'd3);
      bus_wr(BASE + 32'hC, 32'h1);
      bus_wr(BASE, 32'hF0);
      repeat (18) @(posedge clk);
      #1;
      chk("mid_tx_before", tx, 0);
      reset = 1'b0;
      #1;
      chk("mid_tx_reset", tx, 1);
      mr = 1'b1; addr = BASE + 32'h4;
      #1;
      chk("mid_status", rdata, 32'h0000_0004);
      mr = 1'b0; addr = 32'h0;
      @(posedge clk); #1;
      reset = 1'b1;
      rd_lit(BASE + 32'h8, 32'h0000_01B1, "mid_baud");

      // randomized bus traffic
      bus_wr(BASE + 32'h8, 32'd1);
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         mw = 1'b0;
         mr = ($urandom_range(0, 1) == 1);
         addr = BASE + {$urandom_range(0, 3), 2'b00}
                + 32'($urandom_range(0, 3) & 1);
         wdata = $urandom;
         if (r < 30) begin
            mw = 1'b1; addr = BASE;
         end else if (r < 35) begin
            mw = 1'b1; addr = BASE + 32'h8;
            wdata = 32'($urandom_range(0, 3)) | 32'hABCD_0000;
         end else if (r < 43) begin
            mw = 1'b1; addr = BASE + 32'hC;
            if ($urandom_range(0, 3) != 0) wdata[0] = 1'b1;
         end else if (r < 47) begin
            mw = 1'b1; addr = BASE + 32'h4;
         end else if (r < 52) begin
            mw = 1'b1;
            addr = ($urandom_range(0, 1) == 1) ?
                   BASE + 32'h10 : BASE - 32'h10;
         end else if (r < 56) begin
            addr = BASE - 32'h4;
         end
         @(posedge clk); #1;
      end
      mw = 1'b0; mr = 1'b0; addr = 32'h0;
      idle(5);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
